// File: rtl/difficulty_check.sv
// difficulty_check: streams a hash MSW-first and checks its leading-zero count against a programmable difficulty
module difficulty_check #(
    parameter int WORD_WIDTH = 32,
    parameter int N_WORDS    = 8,
    parameter int DIFF_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  diff_load,
    input  logic [DIFF_WIDTH-1:0] diff_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic                  result_valid,
    output logic                  result_pass,
    output logic [DIFF_WIDTH-1:0] lz_count
);
    localparam int HB = WORD_WIDTH * N_WORDS;
    localparam int IW = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
    localparam logic [DIFF_WIDTH-1:0] HB_D = DIFF_WIDTH'(HB);
    localparam logic [DIFF_WIDTH-1:0] WW_D = DIFF_WIDTH'(WORD_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DIFF_WIDTH-1:0] pend_q, pend_d, act_q, act_d, lz_q, lz_d, res_lz_q, res_lz_d;
    logic fail_q, fail_d, allz_q, allz_d, pass_q, pass_d;
    logic accept, first;
    logic [DIFF_WIDTH-1:0] din_sat, act, off, req, wlz;
    logic [WORD_WIDTH-1:0] mask;
    function automatic logic [DIFF_WIDTH-1:0] lzc(input logic [WORD_WIDTH-1:0] w);
        logic [DIFF_WIDTH-1:0] n = '0;
        logic hit = 1'b0;
        for (int b = WORD_WIDTH - 1; b >= 0; b--) begin
            hit = hit | w[b];
            if (!hit) n = n + 1'b1;
        end
        return n;
    endfunction
    always_comb begin
        word_ready   = state_q != REPORT && !reset;
        result_valid = state_q == REPORT;
        result_pass  = pass_q;
        lz_count     = res_lz_q;
        accept       = word_valid & word_ready;
        first        = state_q == IDLE;
        din_sat      = diff_in > HB_D ? HB_D : diff_in;
        // a load coinciding with the word-0 accept takes effect for this hash
        act          = !first ? act_q : diff_load ? din_sat : pend_q;
        off          = DIFF_WIDTH'(idx_q) * WW_D;
        req          = act <= off ? '0 : (act - off >= WW_D ? WW_D : act - off);
        mask         = ~({WORD_WIDTH{1'b1}} >> req);
        wlz          = lzc(word_in);
        pend_d       = diff_load ? din_sat : pend_q;
        state_d      = state_q;
        idx_d        = idx_q;
        act_d        = act_q;
        fail_d       = fail_q;
        allz_d       = allz_q;
        lz_d         = lz_q;
        pass_d       = pass_q;
        res_lz_d     = res_lz_q;
        if (state_q == REPORT) begin
            state_d = IDLE;
        end else if (accept) begin
            act_d   = act;
            fail_d  = (!first & fail_q) | (|(word_in & mask));
            allz_d  = (first | allz_q) & ~|word_in;
            lz_d    = (first ? '0 : lz_q) + ((first | allz_q) ? wlz : '0);
            idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
            state_d = idx_q == LAST ? REPORT : SCAN;
            if (idx_q == LAST) begin
                pass_d   = !fail_d;
                res_lz_d = lz_d;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pend_q   <= '0;
            act_q    <= '0;
            lz_q     <= '0;
            res_lz_q <= '0;
            fail_q   <= 1'b0;
            allz_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            lz_q     <= lz_d;
            res_lz_q <= res_lz_d;
            fail_q   <= fail_d;
            allz_q   <= allz_d;
            pass_q   <= pass_d;
        end
    end
endmodule
